// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer_if
// Description : Instruction-memory request/grant/response bus and fetched
//               instruction valid/ready bus for the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : PC register, branch/jump/jr target selection and a single-
//               outstanding instruction fetch with a one-entry output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        branch_taken,
    input  logic [31:0]                 branch_offset,
    input  logic [31:0]                 redirect_pc4,
    input  logic                        jump,
    input  logic [25:0]                 jump_index,
    input  logic                        jr,
    input  logic [31:0]                 jr_target,
    pc_fetch_sequencer_if.master        bus,
    output logic [31:0]                 pc,
    output logic                        misalign_err
);

    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_REQ  = 2'd1,
        C_WAIT = 2'd2,
        C_HOLD = 2'd3
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [31:0] r_pc_q, w_pc_d;
    logic [31:0] r_addr_q, w_addr_d;
    logic [31:0] r_inst_q, w_inst_d;
    logic [31:0] r_inst_pc_q, w_inst_pc_d;
    logic        r_inst_valid_q, w_inst_valid_d;
    logic        r_kill_q, w_kill_d;
    logic        r_misalign_q, w_misalign_d;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_buf_free;
    logic        w_req;
    logic        w_fire;

    always_comb begin
        w_redirect = jr | jump | branch_taken;
        if (jr) begin
            w_target = jr_target;
        end else if (jump) begin
            w_target = {redirect_pc4[31:28], jump_index, 2'b00};
        end else begin
            w_target = redirect_pc4 + branch_offset;
        end
    end

    // A request is only issued once the buffer can take its response, so the
    // response can never collide with an unaccepted entry.
    assign w_buf_free = !r_inst_valid_q || bus.inst_ready;
    assign w_req      = (r_state_q == C_REQ) && !stall && w_buf_free;
    assign w_fire     = w_req && bus.imem_gnt;

    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_addr_d       = r_addr_q;
        w_inst_d       = r_inst_q;
        w_inst_pc_d    = r_inst_pc_q;
        w_inst_valid_d = r_inst_valid_q && !bus.inst_ready;
        w_kill_d       = r_kill_q;
        w_misalign_d   = r_misalign_q;

        if (w_redirect) begin
            w_pc_d         = w_target & c_ALIGN_MASK;
            w_inst_valid_d = 1'b0;
            if (w_target[1:0] != 2'b00) begin
                w_misalign_d = 1'b1;
            end
        end

        case (r_state_q)
            C_IDLE: begin
                w_state_d = C_REQ;
            end
            C_REQ: begin
                if (w_fire) begin
                    w_addr_d  = r_pc_q;
                    w_state_d = C_WAIT;
                    if (w_redirect) begin
                        w_kill_d = 1'b1;
                    end else begin
                        w_pc_d = r_pc_q + c_PC_STEP;
                    end
                end
            end
            C_WAIT: begin
                if (bus.imem_rvalid) begin
                    // A redirect arriving with the response discards it directly.
                    w_kill_d = 1'b0;
                    if (!r_kill_q && !w_redirect) begin
                        w_inst_d       = bus.imem_rdata;
                        w_inst_pc_d    = r_addr_q;
                        w_inst_valid_d = 1'b1;
                    end
                    w_state_d = stall ? C_HOLD : C_REQ;
                end else if (w_redirect) begin
                    w_kill_d = 1'b1;
                end
            end
            C_HOLD: begin
                if (!stall && w_buf_free) begin
                    w_state_d = C_REQ;
                end
            end
            default: begin
                w_state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q      <= C_IDLE;
            r_pc_q         <= RESET_VECTOR;
            r_addr_q       <= 32'h0;
            r_inst_q       <= 32'h0;
            r_inst_pc_q    <= 32'h0;
            r_inst_valid_q <= 1'b0;
            r_kill_q       <= 1'b0;
            r_misalign_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_addr_q       <= w_addr_d;
            r_inst_q       <= w_inst_d;
            r_inst_pc_q    <= w_inst_pc_d;
            r_inst_valid_q <= w_inst_valid_d;
            r_kill_q       <= w_kill_d;
            r_misalign_q   <= w_misalign_d;
        end
    end

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_pc_q;
    assign bus.inst_valid = r_inst_valid_q;
    assign bus.inst       = r_inst_q;
    assign bus.inst_pc    = r_inst_pc_q;
    assign pc             = r_pc_q;
    assign misalign_err   = r_misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Scoreboard bench for pc_fetch_sequencer with a memory model
//               whose grant budget and response latency are set per phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] c_DATA_OFS     = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'h0;
    logic [31:0] redirect_pc4 = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;
    int gnt_budget = 0;
    int mem_lat = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_inst_q[$];

    pc_fetch_sequencer_if bus();

    assign bus.imem_gnt = bus.imem_req && (gnt_budget > 0);

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.RESET_VECTOR(c_RESET_VECTOR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .redirect_pc4  (redirect_pc4),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .bus           (bus.master),
        .pc            (pc),
        .misalign_err  (misalign_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory model: response 'mem_lat' cycles after the cycle following a grant.
    initial begin
        logic        fire;
        logic        pend;
        logic [31:0] faddr;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0;
        paddr = 32'h0;
        cnt = 0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            fire  = bus.imem_req && bus.imem_gnt;
            faddr = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (fire) begin
                pend = 1'b1;
                paddr = faddr;
                cnt = mem_lat;
                gnt_budget--;
            end
            if (pend) begin
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = paddr + c_DATA_OFS;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Scoreboard monitor: granted addresses and accepted instructions.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: addr %h, no grant expected", bus.imem_addr);
                end else begin
                    check("grant_addr", {32'h0, bus.imem_addr}, {32'h0, exp_addr_q.pop_front()});
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_inst_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_inst: inst %h pc %h, none expected", bus.inst, bus.inst_pc);
                end else begin
                    check("inst_word_pc", {bus.inst, bus.inst_pc}, exp_inst_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.inst_ready = 1'b1;

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
        check("rst_pc", pc, c_RESET_VECTOR);
        check("rst_misalign", misalign_err, 0);

        // First fetches from the reset vector
        tick(1);
        exp_addr_q.push_back(32'h0000_0000);
        exp_addr_q.push_back(32'h0000_0004);
        exp_inst_q.push_back({32'h1000_0000, 32'h0000_0000});
        exp_inst_q.push_back({32'h1000_0004, 32'h0000_0004});
        gnt_budget = 2;
        rst_n = 1'b1;
        tick(10);
        @(negedge clk);
        check("p1_pc", pc, 32'h0000_0008);
        check("p1_req_pending", bus.imem_req, 1);
        check("p1_addr_queue_empty", exp_addr_q.size(), 0);
        check("p1_inst_queue_empty", exp_inst_q.size(), 0);

        // Taken branch while the fetch of 0x8 is still in flight
        tick(1);
        mem_lat = 3;
        exp_addr_q.push_back(32'h0000_0008);
        gnt_budget = 1;
        tick(1);
        branch_taken  = 1'b1;
        redirect_pc4  = 32'h0000_0100;
        branch_offset = 32'hFFFF_FFF0;
        tick(1);
        branch_taken = 1'b0;
        exp_addr_q.push_back(32'h0000_00F0);
        exp_inst_q.push_back({32'h1000_00F0, 32'h0000_00F0});
        gnt_budget = 1;
        @(negedge clk);
        check("p2_pc_redirect", pc, 32'h0000_00F0);
        tick(12);
        check("p2_pc", pc, 32'h0000_00F4);
        check("p2_misalign", misalign_err, 0);
        check("p2_inst_queue_empty", exp_inst_q.size(), 0);
        mem_lat = 0;

        // Jump beats a simultaneous taken branch
        jump          = 1'b1;
        jump_index    = 26'h000_0040;
        branch_taken  = 1'b1;
        redirect_pc4  = 32'h4000_0010;
        branch_offset = 32'h0000_0020;
        tick(1);
        jump = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        check("p3_imem_addr", bus.imem_addr, 32'h4000_0100);
        tick(1);
        exp_addr_q.push_back(32'h4000_0100);
        exp_inst_q.push_back({32'h5000_0100, 32'h4000_0100});
        gnt_budget = 1;
        tick(8);
        check("p3_inst_queue_empty", exp_inst_q.size(), 0);

        // Backpressure: buffer holds, no request until the consumer accepts
        bus.inst_ready = 1'b0;
        exp_addr_q.push_back(32'h4000_0104);
        exp_addr_q.push_back(32'h4000_0108);
        exp_inst_q.push_back({32'h5000_0104, 32'h4000_0104});
        exp_inst_q.push_back({32'h5000_0108, 32'h4000_0108});
        gnt_budget = 2;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.inst_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("p4_inst_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("p4_hold_valid", bus.inst_valid, 1);
            check("p4_hold_inst", {bus.inst, bus.inst_pc}, {32'h5000_0104, 32'h4000_0104});
            check("p4_hold_no_req", bus.imem_req, 0);
        end
        tick(1);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("p4_release_req", bus.imem_req, 1);
        tick(6);
        check("p4_inst_queue_empty", exp_inst_q.size(), 0);

        // Stall blocks requests; then a misaligned jr
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("p5_stall_no_req", bus.imem_req, 0);
        end
        tick(1);
        stall = 1'b0;
        jr = 1'b1;
        jr_target = 32'h0000_0202;
        tick(1);
        jr = 1'b0;
        @(negedge clk);
        check("p5_misalign", misalign_err, 1);
        check("p5_imem_addr", bus.imem_addr, 32'h0000_0200);
        check("p5_req", bus.imem_req, 1);
        tick(1);
        exp_addr_q.push_back(32'h0000_0200);
        exp_inst_q.push_back({32'h1000_0200, 32'h0000_0200});
        gnt_budget = 1;
        tick(6);
        check("p5_inst_queue_empty", exp_inst_q.size(), 0);

        // Reset while waiting; the late response must be ignored
        mem_lat = 4;
        exp_addr_q.push_back(32'h0000_0204);
        gnt_budget = 1;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.imem_rvalid) seen = 1'b1;
            check("p6_inst_valid_low", bus.inst_valid, 0);
        end
        check("p6_late_rvalid_seen", seen, 1);
        check("p6_pc", pc, c_RESET_VECTOR);
        check("p6_misalign_cleared", misalign_err, 0);

        check("end_addr_queue_empty", exp_addr_q.size(), 0);
        check("end_inst_queue_empty", exp_inst_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
